// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage and its surroundings: the request/PC side,
// the memory read handshake, and the instruction-register strobe.
`timescale 1ns/1ps
interface instruction_fetch_if;
    logic        fetchReq;
    logic        pcLoad;
    logic [15:0] pcIn;
    logic [15:0] memData;
    logic        memReady;
    logic [15:0] memAddr;
    logic        notMemRead;
    logic [15:0] irData;
    logic        irNotLoad;
    logic        fetchDone;
    logic        busy;
    logic        fetchError;
    logic [15:0] pc;

    // Environment side: sequencer, memory and instruction register
    modport master (
        output fetchReq, pcLoad, pcIn, memData, memReady,
        input  memAddr, notMemRead, irData, irNotLoad, fetchDone, busy, fetchError, pc
    );

    // Fetch stage side
    modport slave (
        input  fetchReq, pcLoad, pcIn, memData, memReady,
        output memAddr, notMemRead, irData, irNotLoad, fetchDone, busy, fetchError, pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads one instruction word per request through a
// ready handshake bounded by a wait-state limit, then strobes the instruction register.
`timescale 1ns/1ps
module instruction_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MAX_WAIT  = 15,
    parameter int          WAIT_BITS = 4
) (
    input  logic               clock,
    input  logic               notReset,
    instruction_fetch_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WAIT_BITS-1:0] WAIT_ONE   = WAIT_BITS'(1);
    localparam logic [WAIT_BITS-1:0] WAIT_ZERO  = WAIT_BITS'(0);
    localparam logic [WAIT_BITS-1:0] WAIT_LIMIT = WAIT_BITS'(MAX_WAIT);

    state_t               state_q, state_d;
    logic [15:0]          pc_q, pc_d;
    logic [15:0]          ir_q, ir_d;
    logic [WAIT_BITS-1:0] wait_q, wait_d;
    logic                 err_q, err_d;

    // State and datapath registers; reset abandons any in-flight read
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            wait_q  <= WAIT_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                // A same-cycle pcLoad redirects the fetch to pcIn
                if (bus.pcLoad) begin
                    pc_d = bus.pcIn;
                end else begin
                    pc_d = pc_q;
                end
                if (bus.fetchReq && !err_q) begin
                    state_d = S_READ;
                    wait_d  = WAIT_ONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // Ready wins over the timeout on the last allowed cycle
                if (bus.memReady) begin
                    ir_d    = bus.memData;
                    state_d = S_LOAD;
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d  = wait_q + WAIT_ONE;
                end
            end
            S_LOAD: begin
                pc_d    = pc_q + 16'd1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode only the registered state, so they cannot glitch
    assign bus.notMemRead = (state_q != S_READ);
    assign bus.irNotLoad  = (state_q != S_LOAD);
    assign bus.fetchDone  = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.memAddr    = pc_q;
    assign bus.pc         = pc_q;
    assign bus.irData     = ir_q;
    assign bus.fetchError = err_q;
endmodule
